// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding selects and load-use/branch stall-flush control (optional FWD_STALL_CNT_EN stall counter)
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              reg_write_d,
  input  logic              is_load_d,
  input  logic              pc_src_e,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  stall_count
);
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              rw_e, ld_e, rw_m, rw_w, lwstall;
  // shadow pipeline: D->E gets a bubble on flush_e, E->M and M->W always advance
  always_ff @(posedge clk) begin
    if (rst) begin
      {rs1_e, rs2_e, rd_e, rw_e, ld_e} <= '0;
      {rd_m, rw_m, rd_w, rw_w} <= '0;
    end else begin
      rs1_e <= flush_e ? '0 : rs1_d;
      rs2_e <= flush_e ? '0 : rs2_d;
      rd_e  <= flush_e ? '0 : rd_d;
      rw_e  <= flush_e ? 1'b0 : reg_write_d;
      ld_e  <= flush_e ? 1'b0 : is_load_d;
      rd_m  <= rd_e;
      rw_m  <= rw_e;
      rd_w  <= rd_m;
      rw_w  <= rw_m;
    end
  end
  // forwarding selects (MEM beats WB, x0 never forwarded) and hazard strobes; a taken branch overrides the stall
  always_comb begin
    fwd_a_sel = (rw_m && rd_m != '0 && rd_m == rs1_e) ? 2'b10 :
                (rw_w && rd_w != '0 && rd_w == rs1_e) ? 2'b01 : 2'b00;
    fwd_b_sel = (rw_m && rd_m != '0 && rd_m == rs2_e) ? 2'b10 :
                (rw_w && rd_w != '0 && rd_w == rs2_e) ? 2'b01 : 2'b00;
    lwstall   = ld_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
    stall_f   = lwstall && !pc_src_e;
    stall_d   = lwstall && !pc_src_e;
    flush_d   = pc_src_e;
    flush_e   = pc_src_e || lwstall;
  end
`ifdef FWD_STALL_CNT_EN
  // count load-use stall cycles that actually hold the pipeline
  always_ff @(posedge clk) begin
    if (rst) stall_count <= '0;
    else if (lwstall && !pc_src_e) stall_count <= stall_count + CNT_W'(1);
  end
`else
  assign stall_count = '0;
`endif
endmodule
